bram_stream_reader: RTL and testbench

Read-side sequencer for block_ram, and the initiator for its addr/write_enable/data_out port. On a start command it reads a contiguous, wrap-around range of words from one block_ram instance. It accounts for the RAM's one-cycle synchronous read latency and presents the words on a valid/ready stream with full backpressure support. It feeds the vector multiplier datapath from operand memories.

---
 rtl/bram_stream_reader_if.sv | 35 +++
 rtl/bram_stream_reader.sv | 157 +++++++++++++++
 tb/tb_bram_stream_reader.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/bram_stream_reader_if.sv
// bram_stream_reader_if: command, block_ram read port and output stream of the reader.
// Latency: n/a (signal bundle only).
// Backpressure: out_valid/out_ready handshake on the stream side.
// Ports: start/base_addr/length in, busy/done out (command);
//        ram_addr/ram_write_enable out, ram_data_out in (RAM port);
//        out_valid/out_data/out_last out, out_ready in (stream).
interface bram_stream_reader_if #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 3
);
   logic                  start;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic [ADDR_WIDTH:0]   length;
   logic                  busy;
   logic                  done;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic                  ram_write_enable;
   logic [DATA_WIDTH-1:0] ram_data_out;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_last;
   logic                  out_ready;

   // Reader side: issues RAM reads and sources the stream.
   modport master (
      input  start, base_addr, length, ram_data_out, out_ready,
      output busy, done, ram_addr, ram_write_enable, out_valid, out_data, out_last
   );

   // Environment side: commands the reader, models the RAM, sinks the stream.
   modport slave (
      output start, base_addr, length, ram_data_out, out_ready,
      input  busy, done, ram_addr, ram_write_enable, out_valid, out_data, out_last
   );
endinterface

// File: rtl/bram_stream_reader.sv
// bram_stream_reader: streams a wrap-around range of block_ram words onto a valid/ready stream.
// Latency: 3 edges from start to first out_valid, then one word per cycle with out_ready high.
// Backpressure: 2-entry output FIFO; reads stall when FIFO plus in-flight read reach 2 entries.
// Ports: clk_i, rst_ni (async active-low); bus_io (master modport) carries the command
//        (start/base_addr/length/busy/done), RAM port (ram_addr/ram_write_enable/ram_data_out)
//        and stream (out_valid/out_data/out_last/out_ready).
module bram_stream_reader #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   bram_stream_reader_if.master bus_io
);
   localparam int            DEPTH   = 2**ADDR_WIDTH;
   localparam int            LW      = ADDR_WIDTH + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      READ,
      FINISH
   } state_t;

   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [LW-1:0]         len_q, len_d;
   logic [LW-1:0]         issued_q, issued_d;
   logic                  inflight_q, inflight_d;
   logic                  inflight_last_q, inflight_last_d;
   logic [1:0]            cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] dat0_q, dat0_d, dat1_q, dat1_d;
   logic                  last0_q, last0_d, last1_q, last1_d;

   logic [LW-1:0]         len_sat;
   logic                  pop;
   logic                  push;
   logic                  issue;
   logic [1:0]            occ;

   always_comb begin
      len_sat = (bus_io.length > DEPTH_L) ? DEPTH_L : bus_io.length;
      pop     = (cnt_q != 2'd0) && bus_io.out_ready;
      // The RAM answers one cycle after the issue cycle, so an in-flight read is pushed now.
      push    = inflight_q;
      // Projected occupancy after this cycle's pop; max 2 + 1 fits in 2 bits.
      occ     = cnt_q + {1'b0, inflight_q} - {1'b0, pop};
      issue   = (state_q == READ) && (issued_q < len_q) && (occ < 2'd2);

      state_d         = state_q;
      addr_d          = addr_q;
      len_d           = len_q;
      issued_d        = issued_q;
      inflight_d      = issue;
      inflight_last_d = (issued_q + LW'(1)) == len_q;

      case (state_q)
         IDLE: begin
            if (bus_io.start) begin
               len_d    = len_sat;
               issued_d = '0;
               if (len_sat == '0) begin
                  state_d = FINISH;
               end else begin
                  state_d = READ;
                  addr_d  = bus_io.base_addr;
               end
            end
         end
         READ: begin
            if (issue) begin
               // Natural wrap of the ADDR_WIDTH-bit counter gives modulo-DEPTH addressing.
               addr_d   = addr_q + ADDR_WIDTH'(1);
               issued_d = issued_q + LW'(1);
            end
            if (pop && last0_q) begin
               state_d = FINISH;
            end
         end
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Two-slot FIFO, slot 0 is always the head.
      dat0_d  = dat0_q;
      last0_d = last0_q;
      dat1_d  = dat1_q;
      last1_d = last1_q;
      cnt_d   = cnt_q;
      case ({push, pop})
         2'b10: begin
            if (cnt_q == 2'd0) begin
               dat0_d  = bus_io.ram_data_out;
               last0_d = inflight_last_q;
            end else begin
               dat1_d  = bus_io.ram_data_out;
               last1_d = inflight_last_q;
            end
            cnt_d = cnt_q + 2'd1;
         end
         2'b01: begin
            dat0_d  = dat1_q;
            last0_d = last1_q;
            cnt_d   = cnt_q - 2'd1;
         end
         2'b11: begin
            if (cnt_q == 2'd1) begin
               dat0_d  = bus_io.ram_data_out;
               last0_d = inflight_last_q;
            end else begin
               dat0_d  = dat1_q;
               last0_d = last1_q;
               dat1_d  = bus_io.ram_data_out;
               last1_d = inflight_last_q;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q         <= IDLE;
         addr_q          <= '0;
         len_q           <= '0;
         issued_q        <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         cnt_q           <= '0;
         dat0_q          <= '0;
         dat1_q          <= '0;
         last0_q         <= 1'b0;
         last1_q         <= 1'b0;
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         len_q           <= len_d;
         issued_q        <= issued_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         cnt_q           <= cnt_d;
         dat0_q          <= dat0_d;
         dat1_q          <= dat1_d;
         last0_q         <= last0_d;
         last1_q         <= last1_d;
      end
   end

   assign bus_io.busy             = (state_q != IDLE);
   assign bus_io.done             = (state_q == FINISH);
   assign bus_io.ram_addr         = addr_q;
   assign bus_io.ram_write_enable = 1'b0;
   assign bus_io.out_valid        = (cnt_q != 2'd0);
   assign bus_io.out_data         = dat0_q;
   // Slot 0 may hold a stale flag once drained, so qualify with valid.
   assign bus_io.out_last         = (cnt_q != 2'd0) && last0_q;
endmodule

// File: tb/tb_bram_stream_reader.sv
// tb_bram_stream_reader: bench for bram_stream_reader with a synchronous RAM model.
// Expected words come from a queue built as mem[(base+k) mod DEPTH], k < min(length, DEPTH).
// Stream readiness is held high, patterned or randomized per command.
module tb_bram_stream_reader;
   localparam int AW    = 4;
   localparam int DW    = 3;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   bram_stream_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

   bram_stream_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus_io (bus)
   );

   logic [DW-1:0] mem [DEPTH];

   // One-cycle synchronous read, like block_ram.
   always @(posedge clk) bus.ram_data_out <= mem[bus.ram_addr];

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_idle_outputs(input string tag);
      chk({tag, "_busy"}, 32'(bus.busy), 0);
      chk({tag, "_done"}, 32'(bus.done), 0);
      chk({tag, "_vld"},  32'(bus.out_valid), 0);
      chk({tag, "_last"}, 32'(bus.out_last), 0);
      chk({tag, "_addr"}, 32'(bus.ram_addr), 0);
      chk({tag, "_dat"},  32'(bus.out_data), 0);
      chk({tag, "_we"},   32'(bus.ram_write_enable), 0);
   endtask

   // mode 0: ready always 1; mode 1: pattern 1,0,0,1,0,1 from the first valid; mode 2: random.
   // inject: a second start with a different range while busy.
   task automatic run_cmd(input int base, input int len, input int mode, input bit inject);
      int            exp_d[$];
      bit            exp_l[$];
      bit            pat[6];
      int            n, cyc, last_i, first_i, pat_i, nxfer;
      bit            stall_p, popped_last;
      logic [DW-1:0] dat_p;
      logic [AW-1:0] addr0;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      n = (len > DEPTH) ? DEPTH : len;
      for (int k = 0; k < n; k++) begin
         exp_d.push_back(int'(mem[(base + k) % DEPTH]));
         exp_l.push_back(k == n - 1);
      end
      addr0 = bus.ram_addr;
      @(negedge clk);
      bus.start     = 1'b1;
      bus.base_addr = AW'(base);
      bus.length    = (AW+1)'(len);
      bus.out_ready = 1'b1;
      last_i  = (n == 0) ? 0 : -1;
      first_i = -1;
      pat_i   = 0;
      nxfer   = 0;
      stall_p = 1'b0;
      dat_p   = '0;
      cyc     = 0;
      while (cyc < 300) begin
         cyc++;
         @(negedge clk);
         if (cyc == 1) begin
            bus.start = 1'b0;
            chk("first_addr", 32'(bus.ram_addr), (n == 0) ? 32'(addr0) : 32'(base % DEPTH));
         end
         if (inject && cyc == 2) begin
            bus.start     = 1'b1;
            bus.base_addr = AW'(base + 7);
            bus.length    = 5'd3;
         end
         if (inject && cyc == 3) bus.start = 1'b0;
         chk("busy", 32'(bus.busy), 1);
         chk("done", 32'(bus.done), 32'(last_i >= 0 && cyc == last_i + 1));
         chk("we", 32'(bus.ram_write_enable), 0);
         if (stall_p) begin
            chk("hold_vld", 32'(bus.out_valid), 1);
            chk("hold_dat", 32'(bus.out_data), 32'(dat_p));
         end
         if (bus.out_valid && first_i < 0) begin
            first_i = cyc;
            chk("latency", 32'(cyc), 3);
         end
         if (mode == 0 && first_i >= 0 && exp_d.size() > 0)
            chk("thru_vld", 32'(bus.out_valid), 1);
         if (bus.out_valid) begin
            if (exp_d.size() == 0) begin
               chk("extra_word", 1, 0);
            end else begin
               chk("data", 32'(bus.out_data), 32'(exp_d[0]));
               chk("last", 32'(bus.out_last), 32'(exp_l[0]));
            end
         end else begin
            chk("last_novld", 32'(bus.out_last), 0);
         end
         if (last_i >= 0 && cyc == last_i + 1) break;
         case (mode)
            0:       bus.out_ready = 1'b1;
            1: begin
               if (first_i >= 0) begin
                  bus.out_ready = pat[pat_i % 6];
                  pat_i++;
               end else begin
                  bus.out_ready = 1'b1;
               end
            end
            default: bus.out_ready = 1'($urandom_range(0, 1));
         endcase
         if (bus.out_valid && bus.out_ready) begin
            nxfer++;
            if (exp_d.size() > 0) begin
               popped_last = exp_l[0];
               void'(exp_d.pop_front());
               void'(exp_l.pop_front());
               if (popped_last) last_i = cyc;
            end
         end
         stall_p = bus.out_valid && !bus.out_ready;
         dat_p   = bus.out_data;
      end
      if (cyc >= 300) chk("timeout", 0, 1);
      @(negedge clk);
      bus.out_ready = 1'b1;
      chk("busy_end", 32'(bus.busy), 0);
      chk("done_end", 32'(bus.done), 0);
      chk("vld_end", 32'(bus.out_valid), 0);
      chk("nxfer", 32'(nxfer), 32'(n));
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.base_addr = '0;
      bus.length    = '0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < DEPTH; k++) mem[k] = DW'($urandom);
      mem[0]  = 3'd6;
      mem[1]  = 3'd2;
      mem[2]  = 3'd4;
      mem[3]  = 3'd1;
      mem[4]  = 3'd7;
      mem[14] = 3'd3;
      mem[15] = 3'd5;

      repeat (2) @(negedge clk);
      chk_idle_outputs("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_cmd(0, 5, 0, 1'b0);   // basic stream
      run_cmd(1, 3, 1, 1'b0);   // patterned backpressure
      run_cmd(14, 4, 0, 1'b0);  // address wrap
      run_cmd(0, 0, 0, 1'b0);   // empty command
      run_cmd(3, 20, 0, 1'b0);  // saturated length
      run_cmd(2, 5, 0, 1'b1);   // start while busy ignored

      // Reset in the middle of a length-5 read.
      @(negedge clk);
      bus.start     = 1'b1;
      bus.base_addr = 4'd0;
      bus.length    = 5'd5;
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      chk("pre_rst_vld", 32'(bus.out_valid), 1);
      chk("pre_rst_dat", 32'(bus.out_data), 4);
      rst_n = 1'b0;
      #1;
      chk_idle_outputs("midrst");
      repeat (3) begin
         @(negedge clk);
         chk("rst_hold_done", 32'(bus.done), 0);
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_vld", 32'(bus.out_valid), 0);
         chk("post_rst_done", 32'(bus.done), 0);
         chk("post_rst_busy", 32'(bus.busy), 0);
      end
      run_cmd(0, 2, 0, 1'b0);

      // Randomized commands over randomized memory contents.
      for (int t = 0; t < 12; t++) begin
         for (int k = 0; k < DEPTH; k++) mem[k] = DW'($urandom);
         run_cmd(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 20)),
                 int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
